// File: rtl/clock_domain_export_fifo.sv
// Source-side exporter: DEPTH-entry FIFO feeding a 2-phase req/ack handshake.
// Words launch one per round-trip once the synchronized ack matches req.
module clock_domain_export_fifo #(
    parameter int SIZE        = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SIZE-1:0]              data,
    input  logic                         stb,
    output logic                         ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic [SIZE-1:0]              handshake_data,
    output logic                         handshake_req,
    input  logic                         handshake_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE  = LW'(1);
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [SIZE-1:0]        mem_q [DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [SIZE-1:0]        hs_data_q, hs_data_d;
    logic                   req_q, req_d;
    logic                   ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic ack_s;
    logic link_idle;
    logic push;
    logic launch;

    assign ack_s     = sync_q[SYNC_STAGES-1];
    assign link_idle = (ack_s == req_q);
    assign ready     = (level_q != FULL);
    assign push      = stb & ready;
    assign launch    = link_idle & (level_q != '0);

    assign level          = level_q;
    assign busy           = (level_q != '0) | !link_idle;
    assign overflow       = ovf_q;
    assign handshake_data = hs_data_q;
    assign handshake_req  = req_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        hs_data_d = hs_data_q;
        req_d     = req_q;
        ovf_d     = ovf_q;
        if (push) begin
            wptr_d = wptr_q + PONE;
        end
        if (launch) begin
            rptr_d    = rptr_q + PONE;
            hs_data_d = mem_q[rptr_q];
            req_d     = !req_q;
        end
        unique case ({push, launch})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
        // Set takes priority over a same-cycle clear.
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (stb && !ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            hs_data_q <= '0;
            req_q     <= 1'b0;
            ovf_q     <= 1'b0;
            sync_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            hs_data_q <= hs_data_d;
            req_q     <= req_d;
            ovf_q     <= ovf_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], handshake_ack};
        end
    end

endmodule

// File: tb/tb_clock_domain_export_fifo.sv
// Directed bench for clock_domain_export_fifo with loopback or manual ack.
module tb_clock_domain_export_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = '0;
    logic       stb = 1'b0;
    logic       ready;
    logic [2:0] level;
    logic       busy;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [7:0] handshake_data;
    logic       handshake_req;
    logic       handshake_ack;

    logic       loop_en = 1'b0;
    logic       ack_man = 1'b0;
    logic [2:0] dly;
    logic       req_prev;
    int         tog;
    int         tog_base;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = !clk;

    assign handshake_ack = loop_en ? dly[2] : ack_man;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly      <= '0;
            req_prev <= 1'b0;
            tog      <= 0;
        end else begin
            dly      <= {dly[1:0], handshake_req};
            req_prev <= handshake_req;
            if (handshake_req != req_prev) tog <= tog + 1;
        end
    end

    clock_domain_export_fifo #(
        .SIZE(8), .DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .stb            (stb),
        .ready          (ready),
        .level          (level),
        .busy           (busy),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow),
        .handshake_data (handshake_data),
        .handshake_req  (handshake_req),
        .handshake_ack  (handshake_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_launch(input logic [7:0] exp, input string tag);
        logic r0;
        r0 = handshake_req;
        ack_man = !ack_man;
        for (int i = 0; i < 10 && handshake_req == r0; i++) step();
        chk({tag, "_req"}, 32'(handshake_req), 32'(!r0));
        chk({tag, "_data"}, 32'(handshake_data), 32'(exp));
    endtask

    initial begin
        // 1: reset state and first launch via loopback
        #2;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_req", 32'(handshake_req), 32'd0);
        chk("rst_data", 32'(handshake_data), 32'd0);
        step();
        rst_n = 1'b1;
        loop_en = 1'b1;
        step();
        stb = 1'b1; data = 8'hA5;
        step();
        stb = 1'b0;
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_req0", 32'(handshake_req), 32'd0);
        step();
        chk("t1_data", 32'(handshake_data), 32'hA5);
        chk("t1_req1", 32'(handshake_req), 32'd1);
        chk("t1_busy1", 32'(busy), 32'd1);
        for (int i = 0; i < 20 && busy; i++) step();
        chk("t1_busy0", 32'(busy), 32'd0);
        ack_man = 1'b1;
        loop_en = 1'b0;

        // 2: fill FIFO behind one in-flight word
        tog_base = tog;
        stb = 1'b1;
        data = 8'h11; step();
        data = 8'h22; step();
        data = 8'h33; step();
        data = 8'h44; step();
        data = 8'h55; step();
        stb = 1'b0;
        chk("t2_level", 32'(level), 32'd4);
        chk("t2_ready", 32'(ready), 32'd0);
        chk("t2_data", 32'(handshake_data), 32'h11);
        chk("t2_req", 32'(handshake_req), 32'd0);

        // 3: overflow, dropped word, set-beats-clear
        stb = 1'b1; data = 8'h66; step();
        stb = 1'b0;
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_level", 32'(level), 32'd4);
        stb = 1'b1; clr_overflow = 1'b1; step();
        stb = 1'b0;
        chk("t3_ovf_set_wins", 32'(overflow), 32'd1);
        step();
        clr_overflow = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        chk("t3_level2", 32'(level), 32'd4);

        // 4: drain with ack toggles
        wait_launch(8'h22, "t4_w22");
        wait_launch(8'h33, "t4_w33");
        wait_launch(8'h44, "t4_w44");
        wait_launch(8'h55, "t4_w55");
        step();
        chk("t4_level", 32'(level), 32'd0);
        chk("t4_toggles", 32'(tog - tog_base), 32'd5);
        ack_man = 1'b0;
        for (int i = 0; i < 10 && busy; i++) step();
        chk("t4_idle", 32'(busy), 32'd0);

        // 5: push on the same edge as a launch at level 2
        stb = 1'b1;
        data = 8'h01; step();
        data = 8'h02; step();
        data = 8'h03; step();
        stb = 1'b0;
        chk("t5_level_a", 32'(level), 32'd2);
        chk("t5_data1", 32'(handshake_data), 32'h01);
        ack_man = 1'b1;
        step();
        step();
        chk("t5_level_b", 32'(level), 32'd2);
        chk("t5_req_b", 32'(handshake_req), 32'd1);
        stb = 1'b1; data = 8'h04; step();
        stb = 1'b0;
        chk("t5_level_c", 32'(level), 32'd2);
        chk("t5_req_c", 32'(handshake_req), 32'd0);
        chk("t5_data2", 32'(handshake_data), 32'h02);
        wait_launch(8'h03, "t5_w03");
        wait_launch(8'h04, "t5_w04");
        chk("t5_level_d", 32'(level), 32'd0);

        // 6: reset mid-transfer
        stb = 1'b1;
        data = 8'h07; step();
        data = 8'h08; step();
        data = 8'h09; step();
        stb = 1'b0;
        chk("t6_level", 32'(level), 32'd3);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_req", 32'(handshake_req), 32'd0);
        ack_man = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_ready", 32'(ready), 32'd1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        chk("t6_rst_req", 32'(handshake_req), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
